// File: rtl/jpeg_dct_pkg.sv
// Shared definitions for the JPEG encoder zigzag reorder buffer.
//   DATA_W_DEF / ID_W_DEF : default coefficient and block-id widths
//   rd_state_e            : reader state (idle / emitting a block)
//   ZZ2NAT                : zigzag position -> natural (row*8+col) index
//   NAT2ZZ                : natural index -> zigzag position
package jpeg_dct_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ID_W_DEF   = 32;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    localparam logic [5:0] ZZ2NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [5:0] NAT2ZZ [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

endpackage

// File: rtl/jpeg_dct_zigzag_if.sv
// Coefficient input stream and zigzag output stream of the reorder buffer.
//   inport_*  : raster-order coefficients from the quantiser (valid/accept)
//   outport_* : zigzag-order beats to the entropy encoder (valid/accept)
//   slave     : view used by jpeg_dct_zigzag
//   master    : view used by the producer/consumer side
interface jpeg_dct_zigzag_if
    import jpeg_dct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
);
    logic              inport_valid_i;
    logic [DATA_W-1:0] inport_data_i;
    logic [5:0]        inport_idx_i;
    logic [ID_W-1:0]   inport_id_i;
    logic              inport_accept_o;

    logic              outport_valid_o;
    logic [DATA_W-1:0] outport_data_o;
    logic [5:0]        outport_idx_o;
    logic              outport_eob_o;
    logic [ID_W-1:0]   outport_id_o;
    logic              outport_accept_i;

    modport slave (
        input  inport_valid_i, inport_data_i, inport_idx_i, inport_id_i,
        output inport_accept_o,
        output outport_valid_o, outport_data_o, outport_idx_o, outport_eob_o, outport_id_o,
        input  outport_accept_i
    );

    modport master (
        output inport_valid_i, inport_data_i, inport_idx_i, inport_id_i,
        input  inport_accept_o,
        input  outport_valid_o, outport_data_o, outport_idx_o, outport_eob_o, outport_id_o,
        output outport_accept_i
    );
endinterface

// File: rtl/jpeg_dct_zigzag_ram.sv
// Two-bank coefficient store: 128 x DATA_W, one write port, one registered
// read port. Address bit 6 selects the ping-pong bank.
//   clk_i   : clock
//   we_i    : write enable, waddr_i / wdata_i
//   re_i    : read enable; rdata_o updates one cycle later and holds otherwise
module jpeg_dct_zigzag_ram #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [6:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [6:0]        raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [128];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        // Holding the read data while re_i is low lets the pipeline stall
        // without re-reading the array.
        if (re_i) rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/jpeg_dct_zigzag.sv
// Encoder-side zigzag reorder buffer. Takes 8x8 blocks of quantised
// coefficients in raster order, re-emits them in zigzag order up to and
// including the last non-zero coefficient, double-buffered.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   img_start_i  : synchronous flush of both banks and the reader
//   bus          : input/output streams (see jpeg_dct_zigzag_if)
module jpeg_dct_zigzag
    import jpeg_dct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             img_start_i,
    jpeg_dct_zigzag_if.slave bus
);
    // ---------------- bank bookkeeping ----------------
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q;
    logic            rd_bank_q;
    logic [5:0]      last_nz_q, last_nz_new;
    logic [5:0]      bank_last_nz_q [2];
    logic [ID_W-1:0] bank_id_q      [2];

    logic wr_fire, wr_done;

    // ---------------- reader ----------------
    rd_state_e   state_q, state_d;
    logic [6:0]  p_q, p_d;          // next zigzag position to issue (0..64)
    logic        issue, issue_bank, issue_eob, release_blk;
    logic [5:0]  issue_p;
    logic        out_ready, s1_free;

    // Stage 1: RAM read in flight; stage 2: output register.
    logic              s1_vld_q, s1_eob_q;
    logic [5:0]        s1_idx_q;
    logic              out_vld_q, out_eob_q;
    logic [5:0]        out_idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] ram_rdata;

    // ---------------- write side ----------------
    assign bus.inport_accept_o = !full_q[wr_bank_q];
    assign wr_fire = bus.inport_valid_i && bus.inport_accept_o && !img_start_i;
    assign wr_done = wr_fire && (bus.inport_idx_i == 6'd63);

    // Running maximum zigzag position of any non-zero coefficient; folds in
    // the current beat so the idx-63 beat is counted on completion.
    always_comb begin
        last_nz_new = last_nz_q;
        if (wr_fire && (bus.inport_data_i != '0) &&
            (NAT2ZZ[bus.inport_idx_i] > last_nz_q))
            last_nz_new = NAT2ZZ[bus.inport_idx_i];
    end

    // Writer and reader never target the same bank: the writer only fills a
    // non-full bank and the reader only releases a full one.
    always_comb begin
        full_d = full_q;
        if (wr_done)     full_d[wr_bank_q] = 1'b1;
        if (release_blk) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q            <= '0;
            wr_bank_q         <= 1'b0;
            last_nz_q         <= '0;
            bank_last_nz_q[0] <= '0;
            bank_last_nz_q[1] <= '0;
            bank_id_q[0]      <= '0;
            bank_id_q[1]      <= '0;
        end else if (img_start_i) begin
            full_q            <= '0;
            wr_bank_q         <= 1'b0;
            last_nz_q         <= '0;
            bank_last_nz_q[0] <= '0;
            bank_last_nz_q[1] <= '0;
            bank_id_q[0]      <= '0;
            bank_id_q[1]      <= '0;
        end else begin
            full_q <= full_d;
            if (wr_fire) last_nz_q <= wr_done ? 6'd0 : last_nz_new;
            if (wr_done) begin
                bank_last_nz_q[wr_bank_q] <= last_nz_new;
                bank_id_q[wr_bank_q]      <= bus.inport_id_i;
                wr_bank_q                 <= !wr_bank_q;
            end
        end
    end

    // ---------------- reader FSM ----------------
    assign out_ready = !out_vld_q || bus.outport_accept_i;
    // Stage 1 can take a new read if it is empty or drains this cycle.
    assign s1_free   = !s1_vld_q || out_ready;
    assign issue_eob = (issue_p == bank_last_nz_q[issue_bank]);

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        issue       = 1'b0;
        issue_bank  = rd_bank_q;
        issue_p     = p_q[5:0];
        release_blk = 1'b0;
        case (state_q)
            RD_IDLE: begin
                // Issue position 0 on the same cycle the bank is seen full so
                // the first beat is valid two cycles after completion.
                if (full_q[rd_bank_q]) begin
                    issue   = 1'b1;
                    issue_p = 6'd0;
                    p_d     = 7'd1;
                    state_d = RD_ACTIVE;
                end
            end
            RD_ACTIVE: begin
                if (out_vld_q && out_eob_q && bus.outport_accept_i) begin
                    release_blk = 1'b1;
                    // Other bank already waiting: start it now, no idle cycle.
                    if (full_q[~rd_bank_q]) begin
                        issue      = 1'b1;
                        issue_bank = ~rd_bank_q;
                        issue_p    = 6'd0;
                        p_d        = 7'd1;
                    end else begin
                        p_d     = 7'd0;
                        state_d = RD_IDLE;
                    end
                end else if ((p_q <= {1'b0, bank_last_nz_q[rd_bank_q]}) && s1_free) begin
                    issue = 1'b1;
                    p_d   = p_q + 7'd1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RD_IDLE;
            p_q        <= '0;
            rd_bank_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_eob_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_eob_q  <= 1'b0;
        end else if (img_start_i) begin
            state_q    <= RD_IDLE;
            p_q        <= '0;
            rd_bank_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_eob_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_eob_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            if (release_blk) rd_bank_q <= ~rd_bank_q;

            if (issue) begin
                s1_idx_q <= issue_p;
                s1_eob_q <= issue_eob;
            end
            s1_vld_q <= issue || (s1_vld_q && !out_ready);

            if (out_ready) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_data_q <= ram_rdata;
                    out_idx_q  <= s1_idx_q;
                    out_eob_q  <= s1_eob_q;
                end
            end
        end
    end

    jpeg_dct_zigzag_ram #(.DATA_W(DATA_W)) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_fire),
        .waddr_i ({wr_bank_q, bus.inport_idx_i}),
        .wdata_i (bus.inport_data_i),
        .re_i    (issue),
        .raddr_i ({issue_bank, ZZ2NAT[issue_p]}),
        .rdata_o (ram_rdata)
    );

    assign bus.outport_valid_o = out_vld_q;
    assign bus.outport_data_o  = out_data_q;
    assign bus.outport_idx_o   = out_idx_q;
    assign bus.outport_eob_o   = out_eob_q;
    assign bus.outport_id_o    = bank_id_q[rd_bank_q];

endmodule
